// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master round-robin arbiter in front of a single AXI read
//               port. Grants one AR request at a time, forwards it to the
//               bridge, steers R beats back to the owner until rlast, and
//               flags beat-count mismatches against arlen.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int AW = 5,
    parameter int DW = 16,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          res,

    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [1:0]    m0_arburst,
    input  logic [LW-1:0] m0_arlen,
    input  logic [AW-1:0] m0_araddr,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rresp,
    output logic          m0_rlast,
    output logic          m0_rvalid,
    input  logic          m0_rready,

    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [1:0]    m1_arburst,
    input  logic [LW-1:0] m1_arlen,
    input  logic [AW-1:0] m1_araddr,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rresp,
    output logic          m1_rlast,
    output logic          m1_rvalid,
    input  logic          m1_rready,

    output logic          s_arvalid,
    output logic [1:0]    s_arburst,
    output logic [LW-1:0] s_arlen,
    output logic [AW-1:0] s_araddr,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rresp,
    input  logic          s_rlast,
    input  logic          s_rvalid,
    output logic          s_rready,

    output logic [1:0]    grant,
    output logic          busy,
    output logic          len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [LW-1:0] c_cnt_one  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] c_cnt_zero = '0;

    state_t        state_q,    state_d;
    logic [1:0]    grant_q,    grant_d;
    logic          ptr_q,      ptr_d;      // 1 favours m1 on a tie
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic          len_err_q,  len_err_d;

    // Owner-side views of the granted master's request and ready
    logic          w_sel;
    logic          w_g_arvalid;
    logic          w_g_rready;
    logic          w_beat;

    assign w_sel       = grant_q[1];
    assign w_g_arvalid = w_sel ? m1_arvalid : m0_arvalid;
    assign w_g_rready  = w_sel ? m1_rready  : m0_rready;
    assign w_beat      = s_rvalid & w_g_rready;

    // Read data is broadcast to both masters; only rvalid is qualified
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign len_err = len_err_q;

    // State, grant, priority pointer, beat counter and sticky error registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            ptr_q      <= 1'b0;
            beat_cnt_q <= c_cnt_zero;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    // Next-state logic plus channel steering for the current owner
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;

        s_arvalid  = 1'b0;
        s_arburst  = 2'b00;
        s_arlen    = c_cnt_zero;
        s_araddr   = '0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        s_rready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    state_d = ST_ADDR;
                    if (m0_arvalid && m1_arvalid) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else if (m0_arvalid) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
                end
            end

            ST_ADDR: begin
                s_arvalid  = w_g_arvalid;
                s_arburst  = w_sel ? m1_arburst : m0_arburst;
                s_arlen    = w_sel ? m1_arlen   : m0_arlen;
                s_araddr   = w_sel ? m1_araddr  : m0_araddr;
                m0_arready = grant_q[0] & s_arready;
                m1_arready = grant_q[1] & s_arready;
                if (w_g_arvalid && s_arready) begin
                    beat_cnt_d = w_sel ? m1_arlen : m0_arlen;
                    state_d    = ST_DATA;
                end else if (!w_g_arvalid) begin
                    // Request withdrawn: release without touching priority
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end
            end

            ST_DATA: begin
                m0_rvalid = grant_q[0] & s_rvalid;
                m1_rvalid = grant_q[1] & s_rvalid;
                s_rready  = w_g_rready;
                if (w_beat) begin
                    if (s_rlast) begin
                        if (beat_cnt_q != c_cnt_zero) begin
                            len_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        ptr_d   = ~w_sel;
                    end else if (beat_cnt_q == c_cnt_zero) begin
                        // Overrun: counter saturates, keep waiting for rlast
                        len_err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - c_cnt_one;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Self-checking bench for axi_rd_arbiter: directed vector table,
//               hand-written corner sequences and a randomized run against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          res;
    logic [1:0]    m_arvalid;
    logic [1:0]    m_rready;
    logic [1:0]    m_arburst [2];
    logic [LW-1:0] m_arlen   [2];
    logic [AW-1:0] m_araddr  [2];
    logic          s_arready, s_rvalid, s_rlast, s_rresp;
    logic [DW-1:0] s_rdata;

    logic          m0_arready, m1_arready, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rresp, m1_rresp, m0_rlast, m1_rlast;
    logic          s_arvalid, s_rready, busy, len_err;
    logic [1:0]    s_arburst, grant;
    logic [LW-1:0] s_arlen;
    logic [AW-1:0] s_araddr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .res(res),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready), .m0_arburst(m_arburst[0]),
        .m0_arlen(m_arlen[0]), .m0_araddr(m_araddr[0]), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready), .m1_arburst(m_arburst[1]),
        .m1_arlen(m_arlen[1]), .m1_araddr(m_araddr[1]), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]),
        .s_arvalid(s_arvalid), .s_arburst(s_arburst), .s_arlen(s_arlen), .s_araddr(s_araddr),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    // Reference model: who owns the port, whether the address is still
    // outstanding, how many beats remain after the next one, who wins a tie.
    int mo_owner, mo_left, mo_fav;
    bit mo_addr, mo_err;
    int n_owner, n_left, n_fav;
    bit n_addr, n_err_flag;

    typedef struct {
        logic          res;
        logic [1:0]    arv;
        logic [LW-1:0] len0, len1;
        logic          sar, srv, slast;
        logic [1:0]    rrdy;
        logic [DW-1:0] rdata;
        logic [1:0]    e_grant;
        logic          e_busy, e_sarvalid, e_srready;
        logic [1:0]    e_rvalid;
        logic          e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] a, input logic [LW-1:0] l0,
                                input logic [LW-1:0] l1, input logic sar, input logic srv,
                                input logic sl, input logic [1:0] rr, input logic [DW-1:0] d,
                                input logic [1:0] eg, input logic eb, input logic esav,
                                input logic esrr, input logic [1:0] erv, input logic ee);
        vec_t v;
        v.res = r; v.arv = a; v.len0 = l0; v.len1 = l1; v.sar = sar; v.srv = srv;
        v.slast = sl; v.rrdy = rr; v.rdata = d; v.e_grant = eg; v.e_busy = eb;
        v.e_sarvalid = esav; v.e_srready = esrr; v.e_rvalid = erv; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        res = 1'b0; m_arvalid = 2'b00; m_rready = 2'b00;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 1'b0; s_rdata = '0;
    endtask

    task automatic model_reset();
        mo_owner = -1; mo_addr = 1'b0; mo_left = 0; mo_fav = 0; mo_err = 1'b0;
    endtask

    // Compare every DUT output against what the model says for this cycle
    task automatic compare_model();
        int  oi;
        bit  in_addr, in_data;
        logic [1:0] eg;
        logic e_sav;
        oi      = (mo_owner < 0) ? 0 : mo_owner;
        in_addr = (mo_owner >= 0) && mo_addr;
        in_data = (mo_owner >= 0) && !mo_addr;
        eg      = (mo_owner < 0) ? 2'b00 : ((mo_owner == 0) ? 2'b01 : 2'b10);
        e_sav   = in_addr && m_arvalid[oi];
        chk("grant", grant, eg);
        chk("busy", busy, mo_owner >= 0);
        chk("len_err", len_err, mo_err);
        chk("s_arvalid", s_arvalid, e_sav);
        if (e_sav) begin
            chk("s_arlen", s_arlen, m_arlen[oi]);
            chk("s_araddr", s_araddr, m_araddr[oi]);
            chk("s_arburst", s_arburst, m_arburst[oi]);
        end
        chk("m0_arready", m0_arready, in_addr && oi == 0 && s_arready);
        chk("m1_arready", m1_arready, in_addr && oi == 1 && s_arready);
        chk("m0_rvalid", m0_rvalid, in_data && oi == 0 && s_rvalid);
        chk("m1_rvalid", m1_rvalid, in_data && oi == 1 && s_rvalid);
        chk("s_rready", s_rready, in_data && m_rready[oi]);
        chk("m0_rdata", m0_rdata, s_rdata);
        chk("m1_rdata", m1_rdata, s_rdata);
        chk("m0_rlast", m0_rlast, s_rlast);
        chk("m1_rlast", m1_rlast, s_rlast);
        chk("m0_rresp", m0_rresp, s_rresp);
        chk("m1_rresp", m1_rresp, s_rresp);
    endtask

    // Apply the arbitration rules to this cycle's inputs
    task automatic model_next();
        n_owner = mo_owner; n_addr = mo_addr; n_left = mo_left; n_fav = mo_fav; n_err_flag = mo_err;
        if (res) begin
            n_owner = -1; n_addr = 1'b0; n_left = 0; n_fav = 0; n_err_flag = 1'b0;
        end else if (mo_owner < 0) begin
            if (m_arvalid != 2'b00) begin
                n_owner = (m_arvalid == 2'b11) ? mo_fav : (m_arvalid[0] ? 0 : 1);
                n_addr  = 1'b1;
            end
        end else if (mo_addr) begin
            if (m_arvalid[mo_owner] && s_arready) begin
                n_addr = 1'b0;
                n_left = int'(m_arlen[mo_owner]);
            end else if (!m_arvalid[mo_owner]) begin
                n_owner = -1;
            end
        end else if (s_rvalid && m_rready[mo_owner]) begin
            if (s_rlast) begin
                if (mo_left != 0) n_err_flag = 1'b1;
                n_fav   = 1 - mo_owner;
                n_owner = -1;
            end else if (mo_left == 0) begin
                n_err_flag = 1'b1;
            end else begin
                n_left = mo_left - 1;
            end
        end
    endtask

    task automatic cycle();
        #1;
        compare_model();
        model_next();
        @(posedge clk);
        mo_owner = n_owner; mo_addr = n_addr; mo_left = n_left; mo_fav = n_fav; mo_err = n_err_flag;
        @(negedge clk);
    endtask

    int beats;

    initial begin
        vecs[0]  = mk(0, 2'b01, 3, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[1]  = mk(0, 2'b01, 3, 0, 1, 0, 0, 2'b00, 0,  2'b01, 1, 1, 0, 2'b00, 0);
        vecs[2]  = mk(0, 2'b00, 3, 0, 0, 1, 0, 2'b01, 10, 2'b01, 1, 0, 1, 2'b01, 0);
        vecs[3]  = mk(0, 2'b00, 3, 0, 0, 1, 0, 2'b01, 17, 2'b01, 1, 0, 1, 2'b01, 0);
        vecs[4]  = mk(0, 2'b00, 3, 0, 0, 1, 0, 2'b01, 25, 2'b01, 1, 0, 1, 2'b01, 0);
        vecs[5]  = mk(0, 2'b00, 3, 0, 0, 1, 1, 2'b01, 30, 2'b01, 1, 0, 1, 2'b01, 0);
        vecs[6]  = mk(0, 2'b00, 3, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[7]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[8]  = mk(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[9]  = mk(0, 2'b11, 0, 0, 1, 0, 0, 2'b00, 0,  2'b01, 1, 1, 0, 2'b00, 0);
        vecs[10] = mk(0, 2'b10, 0, 0, 0, 1, 1, 2'b01, 5,  2'b01, 1, 0, 1, 2'b01, 0);
        vecs[11] = mk(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[12] = mk(0, 2'b11, 0, 0, 1, 0, 0, 2'b00, 0,  2'b10, 1, 1, 0, 2'b00, 0);
        vecs[13] = mk(0, 2'b11, 0, 0, 0, 1, 1, 2'b10, 6,  2'b10, 1, 0, 1, 2'b10, 0);
        vecs[14] = mk(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[15] = mk(0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0,  2'b01, 1, 1, 0, 2'b00, 0);
        vecs[16] = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0,  2'b01, 1, 0, 0, 2'b00, 0);
        vecs[17] = mk(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);
        vecs[18] = mk(0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0,  2'b01, 1, 1, 0, 2'b00, 0);
        vecs[19] = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0,  2'b01, 1, 0, 0, 2'b00, 0);
        vecs[20] = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0,  2'b00, 0, 0, 0, 2'b00, 0);

        clear_inputs();
        m_arburst[0] = 2'b01; m_arlen[0] = 3; m_araddr[0] = 9;
        m_arburst[1] = 2'b10; m_arlen[1] = 0; m_araddr[1] = 20;
        res = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_rready", s_rready, 1'b0);
        chk("rst_arready", {m1_arready, m0_arready}, 2'b00);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            res = vecs[i].res; m_arvalid = vecs[i].arv;
            m_arlen[0] = vecs[i].len0; m_arlen[1] = vecs[i].len1;
            s_arready = vecs[i].sar; s_rvalid = vecs[i].srv; s_rlast = vecs[i].slast;
            m_rready = vecs[i].rrdy; s_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_s_arvalid", i), s_arvalid, vecs[i].e_sarvalid);
            chk($sformatf("v%0d_s_rready", i), s_rready, vecs[i].e_srready);
            chk($sformatf("v%0d_rvalid", i), {m1_rvalid, m0_rvalid}, vecs[i].e_rvalid);
            chk($sformatf("v%0d_len_err", i), len_err, vecs[i].e_err);
            cycle();
        end
        clear_inputs();

        // Backpressure mid-burst on m0
        m_arlen[0] = 3; beats = 0;
        m_arvalid = 2'b01; cycle();
        s_arready = 1'b1; cycle();
        clear_inputs();
        s_rvalid = 1'b1; m_rready = 2'b01;
        s_rdata = 16'h1111; #1; if (m0_rvalid && m_rready[0]) beats++; cycle();
        s_rdata = 16'h2222; #1; if (m0_rvalid && m_rready[0]) beats++; cycle();
        m_rready = 2'b00; s_rdata = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_s_rready", s_rready, 1'b0);
            chk("bp_m0_rvalid", m0_rvalid, 1'b1);
            chk("bp_m0_rdata", m0_rdata, 16'h3333);
            chk("bp_grant", grant, 2'b01);
            cycle();
        end
        m_rready = 2'b01;
        #1; if (m0_rvalid && m_rready[0]) beats++; cycle();
        s_rdata = 16'h4444; s_rlast = 1'b1;
        #1; if (m0_rvalid && m_rready[0]) beats++; cycle();
        clear_inputs();
        #1;
        chk("bp_beats", beats, 4);
        chk("bp_end_grant", grant, 2'b00);
        chk("bp_end_len_err", len_err, 1'b0);

        // Early rlast on the second beat of a 4-beat m1 burst
        m_arlen[1] = 3; m_arvalid = 2'b10; cycle();
        s_arready = 1'b1; cycle();
        clear_inputs();
        s_rvalid = 1'b1; m_rready = 2'b10; cycle();
        s_rlast = 1'b1; cycle();
        clear_inputs();
        #1;
        chk("early_len_err", len_err, 1'b1);
        chk("early_grant", grant, 2'b00);
        chk("early_busy", busy, 1'b0);
        m_arlen[0] = 0; m_arvalid = 2'b01; cycle();
        s_arready = 1'b1; cycle();
        clear_inputs();
        s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b01; cycle();
        clear_inputs();
        #1;
        chk("sticky_len_err", len_err, 1'b1);
        chk("sticky_grant", grant, 2'b00);

        // Reset asserted on the second data beat
        m_arlen[0] = 3; m_arvalid = 2'b01; cycle();
        s_arready = 1'b1; cycle();
        clear_inputs();
        s_rvalid = 1'b1; m_rready = 2'b01; s_rdata = 16'h00aa; cycle();
        res = 1'b1; s_rdata = 16'h00bb; cycle();
        res = 1'b0;
        #1;
        chk("mrst_grant", grant, 2'b00);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_len_err", len_err, 1'b0);
        chk("mrst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("mrst_s_rready", s_rready, 1'b0);
        chk("mrst_s_arvalid", s_arvalid, 1'b0);
        clear_inputs();
        m_arvalid = 2'b11; cycle();
        #1;
        chk("mrst_tie_grant", grant, 2'b01);
        clear_inputs();
        cycle();
        cycle();

        // Randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            res          = ($urandom_range(0, 299) == 0);
            m_arvalid[0] = ($urandom_range(0, 9) < 6);
            m_arvalid[1] = ($urandom_range(0, 9) < 6);
            m_rready     = 2'($urandom);
            for (int m = 0; m < 2; m++) begin
                m_arlen[m]   = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
                m_araddr[m]  = AW'($urandom);
                m_arburst[m] = 2'($urandom);
            end
            s_arready = ($urandom_range(0, 1) == 1);
            s_rvalid  = ($urandom_range(0, 9) < 6);
            s_rlast   = (mo_left == 0) ^ ($urandom_range(0, 11) == 0);
            s_rresp   = 1'($urandom);
            s_rdata   = DW'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
